// File: rtl/word_parse_ctrl_if.sv
// Character-in / word-out handshake bundle for the Forth word parser.
// The parser sits on the slave side; the driver and consumer use master.
interface word_parse_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int DATA  = 32
);
    localparam int LW = $clog2(WIDTH + 1);

    logic [7:0]         i_char;
    logic               i_char_valid;
    logic               o_char_ready;
    logic [8*WIDTH-1:0] o_word;
    logic [LW-1:0]      o_len;
    logic [DATA-1:0]    o_data;
    logic               o_num;
    logic               o_ovf;
    logic               o_valid;
    logic               i_ready;

    modport slave (
        input  i_char, i_char_valid, i_ready,
        output o_char_ready, o_word, o_len,
        output o_data, o_num, o_ovf, o_valid
    );

    modport master (
        output i_char, i_char_valid, i_ready,
        input  o_char_ready, o_word, o_len,
        input  o_data, o_num, o_ovf, o_valid
    );
endinterface

// File: rtl/word_parse_ctrl.sv
// Forth front end: collects blank-delimited words, converts each
// to a signed integer one char per clock, then presents the result.
module word_parse_ctrl #(
    parameter int WIDTH = 32,
    parameter int DATA  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    word_parse_ctrl_if.slave  bus
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      buf_q [WIDTH];
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [DATA-1:0] acc_q, acc_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            run_q;

    logic            wr_en;
    logic            xfer;
    logic            in_ws;
    logic [7:0]      cur_ch;
    logic            cur_dig;
    logic            cur_minus;
    logic [DATA-1:0] cur_val;

    // Classify the incoming char and the char under conversion
    always_comb begin
        in_ws = 1'b0;
        unique case (1'b1)
            (bus.i_char == 8'h20): in_ws = 1'b1;
            (bus.i_char == 8'h09): in_ws = 1'b1;
            (bus.i_char == 8'h0A): in_ws = 1'b1;
            (bus.i_char == 8'h0D): in_ws = 1'b1;
            default:               in_ws = 1'b0;
        endcase
        cur_ch    = buf_q[idx_q[AW-1:0]];
        cur_dig   = (cur_ch >= 8'h30) && (cur_ch <= 8'h39);
        cur_minus = (cur_ch == 8'h2D);
        cur_val   = {{(DATA-4){1'b0}}, cur_ch[3:0]};
    end

    // Next-state and datapath update for the three-phase sequencer
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        xfer    = bus.i_char_valid & bus.o_char_ready;
        unique case (state_q)
            COLLECT: begin
                if (xfer) begin
                    if (in_ws) begin
                        if (len_q != '0) begin
                            state_d = CONVERT;
                            idx_d   = '0;
                        end
                    end else if (len_q < LW'(WIDTH)) begin
                        wr_en = 1'b1;
                        len_d = len_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            CONVERT: begin
                if ((idx_q == '0) && cur_minus && (len_q > LW'(1))) begin
                    neg_d = 1'b1;
                end else if (cur_dig) begin
                    acc_d = (acc_q << 3) + (acc_q << 1) + cur_val;
                end else begin
                    err_d = 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == len_q - 1'b1) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.i_ready) begin
                    state_d = COLLECT;
                    len_d   = '0;
                    acc_d   = '0;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Control and accumulator registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= COLLECT;
            len_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            run_q   <= 1'b1;
        end
    end

    // Word buffer: append at the current length
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < WIDTH; k++) begin
                buf_q[k] <= 8'h00;
            end
        end else if (wr_en) begin
            buf_q[len_q[AW-1:0]] <= bus.i_char;
        end
    end

    // Result presentation; o_num is gated so nothing leaks out of reset
    always_comb begin
        bus.o_char_ready = run_q && (state_q == COLLECT);
        bus.o_valid      = (state_q == OUTPUT);
        bus.o_num        = bus.o_valid & ~err_q & ~ovf_q;
        bus.o_data       = '0;
        if (bus.o_num) begin
            bus.o_data = neg_q ? (~acc_q + 1'b1) : acc_q;
        end
        bus.o_len = len_q;
        bus.o_ovf = ovf_q;
        for (int k = 0; k < WIDTH; k++) begin
            bus.o_word[8*k +: 8] = buf_q[k];
        end
    end
endmodule

// File: tb/tb_word_parse_ctrl.sv
// Directed bench for word_parse_ctrl: numbers, words, wrap,
// overflow with back-pressure, and reset during conversion.
module tb_word_parse_ctrl;
    localparam int WIDTH = 32;
    localparam int DATA  = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    word_parse_ctrl_if #(.WIDTH(WIDTH), .DATA(DATA)) bus ();

    word_parse_ctrl #(.WIDTH(WIDTH), .DATA(DATA)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_char(input byte c);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            bus.i_char       = c;
            bus.i_char_valid = 1'b1;
            if (bus.o_char_ready) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_char: ready=0 required=1 char=%h", c);
        end
        @(posedge clk);
        #1;
        bus.i_char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
    endtask

    task automatic wait_valid(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < n && !ok; k++) begin
            @(negedge clk);
            if (bus.o_valid) ok = 1'b1;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid: got=%b exp=0", bus.o_valid);
        end
        checks++;
        if (bus.o_char_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready: got=%b exp=0", bus.o_char_ready);
        end
        checks++;
        if ({bus.o_num, bus.o_ovf, bus.o_len, bus.o_data} !== '0) begin
            failures++;
            $display("FAIL rst_outs: num=%b ovf=%b len=%0d data=%h exp=0",
                     bus.o_num, bus.o_ovf, bus.o_len, bus.o_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_positive();
        bit ok;
        send_str("123 ");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.o_char_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
                failures++;
                $display("FAIL conv_cycle%0d: ready=%b valid=%b exp=0/0",
                         k, bus.o_char_ready, bus.o_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_123: valid=%b exp=1", bus.o_valid);
        end
        wait_valid(5, ok);
        checks++;
        if (bus.o_data !== 32'd123 || bus.o_num !== 1'b1) begin
            failures++;
            $display("FAIL num_123: data=%0d num=%b exp=123/1",
                     bus.o_data, bus.o_num);
        end
        checks++;
        if (bus.o_len !== 6'd3 || bus.o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL len_123: len=%0d ovf=%b exp=3/0",
                     bus.o_len, bus.o_ovf);
        end
        checks++;
        if (bus.o_word[23:0] !== 24'h333231) begin
            failures++;
            $display("FAIL word_123: got=%h exp=333231", bus.o_word[23:0]);
        end
        consume();
    endtask

    task automatic test_negative();
        bit ok;
        send_str("  -42\n");
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.o_data !== 32'hFFFFFFD6 || bus.o_num !== 1'b1
            || bus.o_len !== 6'd3) begin
            failures++;
            $display("FAIL neg_42: ok=%b data=%h num=%b len=%0d exp=FFFFFFD6/1/3",
                     ok, bus.o_data, bus.o_num, bus.o_len);
        end
        consume();
        send_str("- ");
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.o_data !== 32'd0 || bus.o_num !== 1'b0
            || bus.o_len !== 6'd1) begin
            failures++;
            $display("FAIL lone_minus: ok=%b data=%h num=%b len=%0d exp=0/0/1",
                     ok, bus.o_data, bus.o_num, bus.o_len);
        end
        consume();
    endtask

    task automatic test_words();
        bit ok;
        send_str("DUP ");
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.o_num !== 1'b0 || bus.o_data !== 32'd0) begin
            failures++;
            $display("FAIL dup_num: ok=%b num=%b data=%h exp=0/0",
                     ok, bus.o_num, bus.o_data);
        end
        checks++;
        if (bus.o_word[23:0] !== 24'h505544 || bus.o_len !== 6'd3) begin
            failures++;
            $display("FAIL dup_word: word=%h len=%0d exp=505544/3",
                     bus.o_word[23:0], bus.o_len);
        end
        consume();
        send_str("1a2 ");
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.o_num !== 1'b0 || bus.o_data !== 32'd0) begin
            failures++;
            $display("FAIL mixed_err: ok=%b num=%b data=%h exp=0/0",
                     ok, bus.o_num, bus.o_data);
        end
        consume();
    endtask

    task automatic test_wrap();
        bit ok;
        send_str("4294967296 ");
        wait_valid(20, ok);
        checks++;
        if (!ok || bus.o_data !== 32'd0 || bus.o_num !== 1'b1
            || bus.o_len !== 6'd10) begin
            failures++;
            $display("FAIL wrap: ok=%b data=%h num=%b len=%0d exp=0/1/10",
                     ok, bus.o_data, bus.o_num, bus.o_len);
        end
        consume();
        send_str("4294967295 ");
        wait_valid(20, ok);
        checks++;
        if (!ok || bus.o_data !== 32'hFFFFFFFF || bus.o_num !== 1'b1) begin
            failures++;
            $display("FAIL max: ok=%b data=%h num=%b exp=FFFFFFFF/1",
                     ok, bus.o_data, bus.o_num);
        end
        consume();
    endtask

    task automatic test_overflow_hold();
        bit ok;
        for (int i = 0; i < 33; i++) send_char(8'h41);
        send_char(8'h20);
        wait_valid(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ovf_valid: valid=%b exp=1", bus.o_valid);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_char_ready !== 1'b0
                || bus.o_ovf !== 1'b1 || bus.o_len !== 6'd32
                || bus.o_num !== 1'b0 || bus.o_data !== 32'd0
                || bus.o_word[255:248] !== 8'h41) begin
                failures++;
                $display("FAIL ovf_hold%0d: v=%b r=%b ovf=%b len=%0d num=%b data=%h exp=1/0/1/32/0/0",
                         k, bus.o_valid, bus.o_char_ready, bus.o_ovf,
                         bus.o_len, bus.o_num, bus.o_data);
            end
            @(negedge clk);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_char_ready !== 1'b1
            || bus.o_ovf !== 1'b0 || bus.o_len !== 6'd0) begin
            failures++;
            $display("FAIL ovf_release: v=%b r=%b ovf=%b len=%0d exp=0/1/0/0",
                     bus.o_valid, bus.o_char_ready, bus.o_ovf, bus.o_len);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_str("9999 ");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_char_ready !== 1'b0
            || bus.o_len !== 6'd0) begin
            failures++;
            $display("FAIL mid_rst: v=%b r=%b len=%0d exp=0/0/0",
                     bus.o_valid, bus.o_char_ready, bus.o_len);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_str("7 ");
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.o_data !== 32'd7 || bus.o_num !== 1'b1
            || bus.o_len !== 6'd1) begin
            failures++;
            $display("FAIL after_rst: ok=%b data=%h num=%b len=%0d exp=7/1/1",
                     ok, bus.o_data, bus.o_num, bus.o_len);
        end
        consume();
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        bus.i_char       = 8'h00;
        bus.i_char_valid = 1'b0;
        bus.i_ready      = 1'b0;
        test_reset();
        test_positive();
        test_negative();
        test_words();
        test_wrap();
        test_overflow_hold();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
